uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the UART transmit FIFO among several on-chip byte producers. Each producer streams bytes over a valid/ready handshake. Once granted, a producer keeps the port for a bounded burst. The burst ends on its last byte, on the burst limit, or on a stall timeout, after which the grant rotates. The arbiter sits between the producers and the TX FIFO's write-enable, write-data and full signals. It honours FIFO backpressure and the shared buffer-clear.

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among NREQ byte producers.
// Grants last one bounded burst; they end on last byte, burst limit or stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  input  logic                    fifo_clear,
  output logic                    fifo_wen,
  output logic [7:0]              fifo_wdata,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);
  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic {ARB, XFER} state_t;

  state_t          stateQ, stateNext;
  logic [IdW-1:0]  ptr, ptrNext, grantNext, cand, searchId;
  logic [CntW-1:0] burstCnt, burstNext, stallCnt, stallNext;
  logic            found, inXfer, gValid, gLast, portOpen, xfer;

  // First valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    found    = 1'b0;
    searchId = ptr;
    cand     = ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IdW'((32'(ptr) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        searchId = cand;
      end
    end
  end

  assign inXfer     = (stateQ == XFER);
  assign gValid     = req_valid[grant_id];
  assign gLast      = req_last[grant_id];
  assign portOpen   = inXfer && !fifo_full && !fifo_clear;
  assign xfer       = portOpen && gValid;
  assign busy       = inXfer;
  assign fifo_wen   = xfer;
  assign fifo_wdata = inXfer ? req_data[{grant_id, 3'b000} +: 8] : 8'h00;

  always_comb begin
    req_ready = '0;
    if (portOpen) req_ready[grant_id] = 1'b1;
  end

  // Next-state logic; a buffer-clear overrides everything but leaves ptr alone
  always_comb begin
    stateNext = stateQ;
    ptrNext   = ptr;
    grantNext = grant_id;
    burstNext = burstCnt;
    stallNext = stallCnt;
    if (fifo_clear) begin
      stateNext = ARB;
      burstNext = '0;
      stallNext = '0;
    end else begin
      case (stateQ)
        ARB: begin
          if (found) begin
            grantNext = searchId;
            burstNext = '0;
            stallNext = '0;
            stateNext = XFER;
          end
        end
        XFER: begin
          if (xfer) begin
            burstNext = (burstCnt == CntMax) ? burstCnt : burstCnt + CntW'(1);
            stallNext = '0;
            if (gLast || (burstCnt >= CntW'(MAX_BURST - 1))) begin
              stateNext = ARB;
              ptrNext   = IdW'((32'(grant_id) + 32'd1) % NREQ);
            end
          end else if (!gValid) begin
            stallNext = (stallCnt == CntMax) ? stallCnt : stallCnt + CntW'(1);
            if (stallCnt >= CntW'(TIMEOUT - 1)) begin
              stateNext = ARB;
              ptrNext   = IdW'((32'(grant_id) + 32'd1) % NREQ);
            end
          end
        end
        default: stateNext = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stateQ   <= ARB;
      ptr      <= '0;
      grant_id <= '0;
      burstCnt <= '0;
      stallCnt <= '0;
    end else begin
      stateQ   <= stateNext;
      ptr      <= ptrNext;
      grant_id <= grantNext;
      burstCnt <= burstNext;
      stallCnt <= stallNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester model, write scoreboard and cycle checks.
module tb_uart_tx_arbiter;
  localparam int unsigned NREQ = 4;

  logic        clk = 1'b0;
  logic        nReset;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        fifo_full, fifo_clear, fifo_wen, busy;
  logic [7:0]  fifo_wdata;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .MAX_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .nReset(nReset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_clear(fifo_clear),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .grant_id(grant_id), .busy(busy)
  );

  int          compared = 0;
  int          mismatched = 0;
  int          remain [NREQ];
  logic [7:0]  nextByte [NREQ];
  logic        lastOnEnd [NREQ];
  logic [15:0] expQ [$];
  logic        wenS, busyS;
  logic [1:0]  gidS;
  logic [3:0]  readyS;
  logic [4:0]  wenH;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = remain[i] > 0;
      req_last[i]        = lastOnEnd[i] && (remain[i] == 1);
      req_data[8*i +: 8] = nextByte[i];
    end
  endtask

  // Snapshot outputs mid-cycle, score writes, advance requesters on handshakes
  task automatic sample();
    logic [15:0] e;
    wenS = fifo_wen; busyS = busy; gidS = grant_id; readyS = req_ready;
    if (fifo_wen) begin
      check("sb_has_entry", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("sb_write", 32'({8'(grant_id), fifo_wdata}), 32'(e));
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        remain[i]--;
        nextByte[i]++;
      end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic load(input int id, input int n, input logic [7:0] first, input logic last);
    remain[id] = n; nextByte[id] = first; lastOnEnd[id] = last;
  endtask

  task automatic expectBytes(input int id, input logic [7:0] first, input int n);
    for (int b = 0; b < n; b++) expQ.push_back({8'(id), 8'(first + 8'(b))});
  endtask

  task automatic clearModel();
    for (int i = 0; i < NREQ; i++) begin
      remain[i] = 0; nextByte[i] = 8'h00; lastOnEnd[i] = 1'b0;
    end
    expQ.delete();
    drive();
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wen"}, 32'(fifo_wen), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_wdata"}, 32'(fifo_wdata), 32'd0);
    check({tag, "_gid"}, 32'(grant_id), 32'd0);
  endtask

  task automatic doReset();
    nReset = 1'b0;
    clearModel();
    #1;
    checkResetValues("reset");
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fifo_full = 1'b0; fifo_clear = 1'b0;
    doReset();

    // Single requester 2, three bytes, last on the third
    load(2, 3, 8'h41, 1'b1);
    expectBytes(2, 8'h41, 3);
    for (int k = 0; k < 5; k++) begin
      cycle();
      wenH[k] = wenS;
      if (k == 1) begin
        check("s1_gid", 32'(gidS), 32'd2);
        check("s1_ready", 32'(readyS), 32'h4);
      end
      if (k == 4) check("s1_busy_after", 32'(busyS), 32'd0);
    end
    check("s1_wen_pattern", 32'(wenH), 32'b01110);

    // ptr is now 3: requester 3 wins over 0
    load(0, 1, 8'h50, 1'b1);
    load(3, 1, 8'h58, 1'b1);
    expectBytes(3, 8'h58, 1);
    expectBytes(0, 8'h50, 1);
    cycle();
    cycle();
    check("s1b_gid_first", 32'(gidS), 32'd3);
    run(3);

    // All four continuously valid: 4 writes then one dead cycle per grant
    doReset();
    for (int i = 0; i < NREQ; i++) load(i, 8, 8'(8'h10 + 8'(i * 32)), 1'b0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) expectBytes(i, 8'(8'h10 + 8'(i * 32) + 8'(4 * r)), 4);
    for (int k = 0; k < 40; k++) begin
      cycle();
      check("s2_wen", 32'(wenS), 32'((k % 5) != 0));
      if ((k % 5) == 1) check("s2_gid", 32'(gidS), 32'((k / 5) % 4));
    end
    cycle();
    check("s2_idle", 32'(busyS), 32'd0);

    // Requester 1 with FIFO full held mid-burst; burst count must survive
    load(1, 6, 8'h60, 1'b1);
    expectBytes(1, 8'h60, 6);
    run(3);
    fifo_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("s3_full_wen", 32'(wenS), 32'd0);
      check("s3_full_busy", 32'(busyS), 32'd1);
      check("s3_full_ready", 32'(readyS), 32'd0);
    end
    fifo_full = 1'b0;
    cycle();
    check("s3_resume_wen", 32'(wenS), 32'd1);
    cycle();
    check("s3_limit_wen", 32'(wenS), 32'd1);
    cycle();
    check("s3_release", 32'(busyS), 32'd0);
    run(3);

    // Requester 0 goes idle while granted; timeout then requester 3
    load(0, 2, 8'h70, 1'b0);
    expectBytes(0, 8'h70, 2);
    run(3);
    load(3, 1, 8'h80, 1'b1);
    expectBytes(3, 8'h80, 1);
    for (int k = 0; k < 16; k++) begin
      cycle();
      check("s4_stall_busy", 32'(busyS), 32'd1);
      check("s4_stall_wen", 32'(wenS), 32'd0);
    end
    cycle();
    check("s4_timeout_release", 32'(busyS), 32'd0);
    cycle();
    check("s4_next_gid", 32'(gidS), 32'd3);
    check("s4_next_wen", 32'(wenS), 32'd1);
    cycle();

    // Buffer-clear during a transfer from requester 1
    load(1, 3, 8'h90, 1'b1);
    expectBytes(1, 8'h90, 3);
    expectBytes(2, 8'hA0, 1);
    run(2);
    fifo_clear = 1'b1;
    cycle();
    check("s5_clear_wen", 32'(wenS), 32'd0);
    check("s5_clear_ready", 32'(readyS), 32'd0);
    fifo_clear = 1'b0;
    load(2, 1, 8'hA0, 1'b1);
    cycle();
    check("s5_arb_after_clear", 32'(busyS), 32'd0);
    cycle();
    check("s5_ptr_kept_gid", 32'(gidS), 32'd1);
    run(4);

    // Reset mid-burst from requester 2
    load(2, 4, 8'h20, 1'b0);
    expectBytes(2, 8'h20, 4);
    run(3);
    check("s6_pre_reset_wen", 32'(fifo_wen), 32'd1);
    nReset = 1'b0;
    #1;
    check("s6_rst_wen", 32'(fifo_wen), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_ready", 32'(req_ready), 32'd0);
    clearModel();
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;
    load(1, 1, 8'hB0, 1'b1);
    load(3, 1, 8'hC0, 1'b1);
    expectBytes(1, 8'hB0, 1);
    expectBytes(3, 8'hC0, 1);
    cycle();
    cycle();
    check("s6_lowest_gid", 32'(gidS), 32'd1);
    run(3);

    check("sb_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
